acc_sequencer: RTL and testbench
================================

ACC_SEQUENCER -- requirements
Module: acc_sequencer

Interface
REQ-001 SHALL have parameter N, default 4, meaning operand and sum width in bits.
REQ-002 SHALL have parameter LW, default 4, meaning width of the operand-count input len.
REQ-003 SHALL have one clock and asynchronous, active-high reset, as listed in REQ-004 and REQ-005.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 start  input  1  request a new accumulation run; sampled only in IDLE.
REQ-007 len  input  LW  number of operands in the run; sampled with start.
REQ-008 in_valid  input  1  in_data holds a valid operand.
REQ-009 in_ready  output  1  block accepts an operand this cycle.
REQ-010 in_data  input  N  operand to add.
REQ-011 out_valid  output  1  result is valid.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 out_sum  output  N  accumulated sum.
REQ-014 out_ovf  output  1  a carry out of bit N-1 occurred during the run.
REQ-015 busy  output  1  state is not IDLE.

Function
REQ-016 SHALL implement three states: IDLE, ACCUM, DONE.
REQ-017 IDLE: in_ready=0, out_valid=0, busy=0.
REQ-018 IDLE with start=1 at a clock edge: acc<=0, ovf<=0, cnt<=len; next state DONE if len==0, else ACCUM.
REQ-019 start outside IDLE SHALL be ignored with no effect on state or outputs.
REQ-020 ACCUM: in_ready=1 combinationally; a transfer occurs when in_valid=1 and in_ready=1 at a clock edge.
REQ-021 Each transfer: {c,acc} <= acc + in_data (N+1-bit add), ovf <= ovf | c, cnt <= cnt-1.
REQ-022 A transfer with cnt==1 SHALL move to DONE, so out_valid rises exactly one cycle after the last transfer.
REQ-023 in_valid=0 in ACCUM SHALL hold acc, ovf and cnt unchanged; there is no timeout.
REQ-024 DONE: out_valid=1, out_sum=acc, out_ovf=ovf, in_ready=0.
REQ-025 DONE: out_valid=1 with out_ready=1 at an edge SHALL move to IDLE; start on that same edge is ignored.
REQ-026 While out_valid=1 and out_ready=0, out_sum and out_ovf SHALL be held stable.
REQ-027 out_sum and out_ovf SHALL read 0 whenever out_valid=0.
REQ-028 len SHALL be treated as unsigned; a run of up to 2^LW-1 operands SHALL be supported.

Reset
REQ-029 rst=1 SHALL immediately force IDLE with acc=0, ovf=0, cnt=0, independent of clk.
REQ-030 During and after reset: in_ready=0, out_valid=0, out_sum=0, out_ovf=0, busy=0.
REQ-031 Reset asserted mid-ACCUM or in DONE SHALL abandon the run; no result is produced.

Configuration
REQ-032 Macro ACC_SATURATE_EN SHALL select the overflow behaviour.
REQ-033 With ACC_SATURATE_EN defined: on any carry, acc SHALL become all-ones and remain all-ones for the rest of the run; ovf is still set.
REQ-034 Without ACC_SATURATE_EN: acc SHALL wrap modulo 2^N; ovf records the carry.

Verification
REQ-035 N=4, start with len=3, operands 1,2,3 back-to-back -> out_valid one cycle after the third transfer, out_sum=6, out_ovf=0.
REQ-036 len=2, operands 15,2 -> out_sum=1 and out_ovf=1 without ACC_SATURATE_EN; out_sum=15 and out_ovf=1 with it.
REQ-037 len=0 with start -> out_valid=1 next cycle, out_sum=0, out_ovf=0, no in_ready pulse.
REQ-038 len=3, in_valid gaps between operands, out_ready low 5 cycles in DONE -> out_sum=6 held all 5 cycles; IDLE one cycle after out_ready rises.
REQ-039 rst pulsed after 2 of 4 transfers -> all outputs 0 immediately; a new run with len=1, operand 7 -> out_sum=7.
REQ-040 start asserted during ACCUM and on the DONE accept edge -> ignored; state reaches IDLE only, no new run begins.

Source files
------------

// File: rtl/acc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : acc_sequencer
// Brief    : Counted accumulator with valid/ready operand input and result
//            output. Macro ACC_SATURATE_EN selects saturating overflow.
// Revision : 1.0 - initial release
// ============================================================================
module acc_sequencer #(
  parameter int N  = 4,
  parameter int LW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [LW-1:0] len,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_sum,
  output logic          out_ovf,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        r_state;
  logic [N-1:0]  r_acc;
  logic          r_ovf;
  logic [LW-1:0] r_cnt;
  logic          r_in_ready;
  logic          r_out_valid;
  logic          r_busy;

  logic          w_xfer;
  logic [N:0]    w_sum;
  logic [N-1:0]  w_acc_next;

  assign w_xfer = r_in_ready & in_valid;
  assign w_sum  = {1'b0, r_acc} + {1'b0, in_data};

`ifdef ACC_SATURATE_EN
  // Once any carry has been seen the accumulator pins at all-ones for the run.
  assign w_acc_next = (w_sum[N] | r_ovf) ? {N{1'b1}} : w_sum[N-1:0];
`else
  assign w_acc_next = w_sum[N-1:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_acc  <= '0;
            r_ovf  <= 1'b0;
            r_cnt  <= len;
            r_busy <= 1'b1;
            if (len == '0) begin
              r_state     <= DONE;
              r_out_valid <= 1'b1;
            end else begin
              r_state    <= ACCUM;
              r_in_ready <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (w_xfer) begin
            r_acc <= w_acc_next;
            r_ovf <= r_ovf | w_sum[N];
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == {{(LW-1){1'b0}}, 1'b1}) begin
              r_state     <= DONE;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  // Result fields are masked so they read zero outside DONE.
  assign out_sum   = r_out_valid ? r_acc : '0;
  assign out_ovf   = r_out_valid & r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_acc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_acc_sequencer
// Brief    : Scoreboard bench for acc_sequencer with a run-level sum model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_acc_sequencer;
  localparam int N  = 4;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] len = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [N-1:0]  out_sum;
  logic          out_ovf;
  logic          busy;

  int total = 0;
  int bad   = 0;
  logic [N:0] exp_q[$];
  int ops_q[$];

  acc_sequencer #(.N(N), .LW(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_ovf(out_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Run-level model: the true integer total decides overflow and the result.
  function automatic logic [N:0] model();
    int t = 0;
    logic ovf;
    logic [N-1:0] s;
    foreach (ops_q[i]) t += ops_q[i];
    ovf = (t >= (1 << N));
`ifdef ACC_SATURATE_EN
    s = ovf ? {N{1'b1}} : t[N-1:0];
`else
    s = t[N-1:0];
`endif
    return {ovf, s};
  endfunction

  // Monitor: zero when idle, stable under back-pressure, scoreboard on accept.
  logic         holding = 1'b0;
  logic [N-1:0] h_sum;
  logic         h_ovf;
  always @(negedge clk) begin
    logic [N:0] e;
    if (out_valid) begin
      if (holding) begin
        chk("hold_sum", 32'(out_sum), 32'(h_sum));
        chk("hold_ovf", 32'(out_ovf), 32'(h_ovf));
      end
      if (!out_ready) begin
        holding = 1'b1;
        h_sum   = out_sum;
        h_ovf   = out_ovf;
      end else begin
        holding = 1'b0;
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("out_sum", 32'(out_sum), 32'(e[N-1:0]));
          chk("out_ovf", 32'(out_ovf), 32'(e[N]));
        end
      end
    end else begin
      holding = 1'b0;
      chk("idle_zero", {30'd0, out_ovf, |out_sum}, 32'd0);
    end
  end

  // One run: operands from ops_q, random gaps, stall cycles in DONE,
  // optional start noise, optional reset after abort_after transfers.
  task automatic do_run(input int gapmax, input int stall, input bit noise, input int abort_after);
    bit got;
    exp_q.push_back(model());
    start = 1'b1;
    len   = LW'(ops_q.size());
    @(posedge clk); #1;
    start = noise;
    if (ops_q.size() == 0) begin
      @(negedge clk);
      chk("len0_valid", 32'(out_valid), 32'd1);
      chk("len0_no_ready", 32'(in_ready), 32'd0);
    end
    for (int i = 0; i < ops_q.size(); i++) begin
      if (i == abort_after) begin
        #2 rst = 1'b1;
        #1;
        chk("rst_outputs", {27'd0, in_ready, out_valid, out_ovf, busy, |out_sum}, 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("rst_idle_busy", 32'(busy), 32'd0);
        return;
      end
      repeat ($urandom_range(0, gapmax)) begin
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = N'(ops_q[i]);
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
        @(negedge clk);
        got = in_ready;
      end
      if (!got) chk("in_ready_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = N'($urandom);
    end
    if (ops_q.size() != 0) begin
      @(negedge clk);
      chk("done_latency", 32'(out_valid), 32'd1);
    end
    repeat (stall + 1) @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    start     = 1'b0;
    @(negedge clk);
    chk("idle_after_accept", {30'd0, busy, out_valid}, 32'd0);
  endtask

  initial begin
    #1;
    chk("reset_outputs", {27'd0, in_ready, out_valid, out_ovf, busy, |out_sum}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_reset_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;

    ops_q = '{1, 2, 3};        do_run(0, 0, 1'b0, -1);
    ops_q = '{15, 2};          do_run(0, 1, 1'b0, -1);
    ops_q.delete();            do_run(0, 0, 1'b0, -1);
    ops_q = '{1, 2, 3};        do_run(3, 5, 1'b0, -1);
    ops_q = '{4, 5, 6, 7};     do_run(1, 0, 1'b0, 2);
    ops_q = '{7};              do_run(0, 0, 1'b0, -1);
    ops_q = '{3, 9, 8};        do_run(2, 2, 1'b1, -1);
    ops_q = '{15, 0, 15, 1};   do_run(0, 0, 1'b0, -1);

    for (int r = 0; r < 25; r++) begin
      int n;
      n = (r == 0) ? (1 << LW) - 1 : int'($urandom_range(0, (1 << LW) - 1));
      ops_q.delete();
      for (int j = 0; j < n; j++) ops_q.push_back(int'($urandom_range(0, (1 << N) - 1)));
      do_run(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'($urandom), -1);
    end

    repeat (3) @(posedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
